rpn_eval: RTL
=============

Name: rpn_eval

Overview:
Token-driven reverse-Polish evaluator that sits directly upstream of the 16-entry byte stack and is its only master. It drives the stack's push/pop/data_in, and reads data_out and error. Operand tokens are pushed. Operator tokens pop two entries, compute, and push the result. A RESULT token pops the top entry and presents it on a valid/ready output. Stack and evaluator share clk and reset.

Parameters:
DATA_WIDTH, 8, operand/result width; must match the stack.
DEPTH, 16, stack capacity; used for the local occupancy count and overflow pre-check.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; also resets the attached stack
tok_valid  input  1  token present
tok_ready  output  1  evaluator can accept a token
tok_is_op  input  1  1 = tok_data is an opcode, 0 = operand
tok_data  input  DATA_WIDTH  operand value or opcode
res_valid  output  1  result/error record present
res_ready  input  1  consumer accepts record
res_data  output  DATA_WIDTH  popped result value (0 when res_err=1)
res_err  output  1  record is an error
res_code  output  2  0 none, 1 underflow, 2 overflow, 3 illegal opcode / stack fault
stk_push  output  1  stack push strobe, 1 cycle
stk_pop  output  1  stack pop strobe, 1 cycle
stk_data_in  output  DATA_WIDTH  value to push
stk_data_out  input  DATA_WIDTH  stack top; valid the cycle after stk_pop
stk_error  input  1  stack over/underflow flag

Behaviour:
- Reset values: tok_ready=0 during reset (1 the cycle after reset releases), res_valid=0, res_data=0, res_err=0, res_code=0, stk_push=0, stk_pop=0, stk_data_in=0, occupancy count=0, state=IDLE.
- Handshake: token transfers when tok_valid&tok_ready. tok_ready=1 only in IDLE. Record transfers when res_valid&res_ready. res_valid and all res_* hold stable until accepted.
- Opcodes: 0x00 ADD, 0x01 SUB (A-B, A=deeper entry, B=top), 0x02 AND, 0x03 OR, 0x04 XOR, 0x0F RESULT. All others are illegal.
- Arithmetic is modulo 2^DATA_WIDTH. There are no carry or borrow flags.
- States: IDLE, PUSH, POP_B, WAIT_B, POP_A, WAIT_A, EXEC, POP_R, WAIT_R, OUT.
- Operand accepted in cycle N:
  - Precheck count<DEPTH.
  - PUSH at N+1: stk_push=1, stk_data_in=operand, count+1.
  - Return to IDLE; tok_ready=1 at N+2.
- Binary op accepted in cycle N:
  - Precheck count>=2.
  - POP_B at N+1, B captured in WAIT_B (N+2).
  - POP_A at N+3, A captured at N+4.
  - EXEC at N+5 pushes the result; net count-1.
  - tok_ready=1 at N+6.
- RESULT accepted in cycle N:
  - Precheck count>=1.
  - POP_R at N+1, capture at N+2.
  - OUT from N+3: res_valid=1, res_err=0, res_data=value; count-1.
  - Back to IDLE the cycle after acceptance.
- Failed precheck or illegal opcode:
  - No stack strobes are issued; count is unchanged.
  - Go directly to OUT with res_err=1 and the matching code (1/2/3), res_data=0.
- stk_error sampled high in any WAIT_* or in the cycle after PUSH/EXEC:
  - Abort to OUT, code 3.
  - count forced to 0; software must reset the stack.
- stk_push and stk_pop are never asserted in the same cycle. Each is at most 1 cycle wide.
- Count boundaries:
  - Pushing at count=DEPTH-1 is legal and reaches count=DEPTH.
  - A binary op at count=DEPTH is legal (pop, pop, push).
- Reset mid-operation aborts immediately to the reset values above. A pending token is not accepted and a pending record is dropped.

Optional Feature:
RPN_MUL_EN: when defined, opcode 0x05 MUL is legal and yields the low DATA_WIDTH bits of A*B, with the same timing as the other binary ops. When undefined, 0x05 is illegal (code 3) and no multiplier is synthesized.

Test Plan:
- Push 0x05, push 0x03, ADD, RESULT -> one record res_data=0x08, res_err=0; stack empty afterwards.
- Push 0x02, push 0x05, SUB, RESULT -> res_data=0xFD (wrap), res_err=0.
- Push 0x00..0x0F (16 operands), then push 0x10 -> record res_err=1, res_code=2; no stk_push on 17th; subsequent RESULT returns 0x0F.
- Empty stack: ADD -> res_code=1, no stk_pop issued. Then RESULT -> res_code=1.
- Opcode 0x07 with one entry -> res_code=3, entry intact; then RESULT -> original value. Hold res_ready=0 for 5 cycles and check res_* stay stable.
- With RPN_MUL_EN: push 0x10, push 0x11, MUL, RESULT -> 0x10. Without it, MUL -> res_code=3. Assert reset mid-binary-op (in WAIT_A) -> all outputs at reset values the next cycle, count=0.

Source files
------------

// File: rtl/rpn_eval.sv
// ============================================================================
//  Module      : rpn_eval
//  Description : Token-driven reverse-Polish evaluator; sole master of an
//                external byte stack. Optional MUL opcode via RPN_MUL_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rpn_eval #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tok_valid_i,
  output logic                  tok_ready_o,
  input  logic                  tok_is_op_i,
  input  logic [DATA_WIDTH-1:0] tok_data_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic                  res_err_o,
  output logic [1:0]            res_code_o,
  output logic                  stk_push_o,
  output logic                  stk_pop_o,
  output logic [DATA_WIDTH-1:0] stk_data_in_o,
  input  logic [DATA_WIDTH-1:0] stk_data_out_i,
  input  logic                  stk_error_i
);

  localparam int                  c_CNT_W  = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0]  c_DEPTH  = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0]  c_ONE    = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]  c_TWO    = c_CNT_W'(2);

  localparam logic [DATA_WIDTH-1:0] c_OP_ADD    = DATA_WIDTH'('h00);
  localparam logic [DATA_WIDTH-1:0] c_OP_SUB    = DATA_WIDTH'('h01);
  localparam logic [DATA_WIDTH-1:0] c_OP_AND    = DATA_WIDTH'('h02);
  localparam logic [DATA_WIDTH-1:0] c_OP_OR     = DATA_WIDTH'('h03);
  localparam logic [DATA_WIDTH-1:0] c_OP_XOR    = DATA_WIDTH'('h04);
`ifdef RPN_MUL_EN
  localparam logic [DATA_WIDTH-1:0] c_OP_MUL    = DATA_WIDTH'('h05);
`endif
  localparam logic [DATA_WIDTH-1:0] c_OP_RESULT = DATA_WIDTH'('h0F);

  localparam logic [1:0] c_CODE_UNDER = 2'd1;
  localparam logic [1:0] c_CODE_OVER  = 2'd2;
  localparam logic [1:0] c_CODE_FAULT = 2'd3;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    PUSH   = 4'd1,
    POP_B  = 4'd2,
    WAIT_B = 4'd3,
    POP_A  = 4'd4,
    WAIT_A = 4'd5,
    EXEC   = 4'd6,
    POP_R  = 4'd7,
    WAIT_R = 4'd8,
    OUT    = 4'd9
  } state_t;

  state_t                  state_q, state_d;
  logic [c_CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0]   opnd_q, opnd_d;
  logic [DATA_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [DATA_WIDTH-1:0]   res_data_q, res_data_d;
  logic                    res_err_q, res_err_d;
  logic [1:0]              res_code_q, res_code_d;
  logic                    post_push_q, post_push_d;

  logic                    w_op_legal;
  logic [DATA_WIDTH-1:0]   w_alu;
  logic                    w_err;
  logic [1:0]              w_err_code;
  logic                    w_fault;

  always_comb begin
    w_op_legal = 1'b0;
    case (tok_data_i)
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR: w_op_legal = 1'b1;
`ifdef RPN_MUL_EN
      c_OP_MUL: w_op_legal = 1'b1;
`endif
      default: w_op_legal = 1'b0;
    endcase
  end

  // A = deeper entry, B = top of stack; all results wrap modulo 2^DATA_WIDTH
  always_comb begin
    w_alu = '0;
    case (op_q)
      c_OP_ADD: w_alu = a_q + b_q;
      c_OP_SUB: w_alu = a_q - b_q;
      c_OP_AND: w_alu = a_q & b_q;
      c_OP_OR:  w_alu = a_q | b_q;
      c_OP_XOR: w_alu = a_q ^ b_q;
`ifdef RPN_MUL_EN
      c_OP_MUL: w_alu = a_q * b_q;
`endif
      default:  w_alu = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    opnd_d        = opnd_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    res_data_d    = res_data_q;
    res_err_d     = res_err_q;
    res_code_d    = res_code_q;
    post_push_d   = 1'b0;
    tok_ready_o   = 1'b0;
    stk_push_o    = 1'b0;
    stk_pop_o     = 1'b0;
    stk_data_in_o = '0;
    w_err         = 1'b0;
    w_err_code    = c_CODE_FAULT;
    w_fault       = 1'b0;

    case (state_q)
      IDLE: begin
        // stack error flag lags the push by one cycle, so it is checked here
        if (post_push_q && stk_error_i) begin
          w_fault = 1'b1;
        end else begin
          tok_ready_o = 1'b1;
          if (tok_valid_i) begin
            if (!tok_is_op_i) begin
              if (count_q < c_DEPTH) begin
                opnd_d  = tok_data_i;
                state_d = PUSH;
              end else begin
                w_err      = 1'b1;
                w_err_code = c_CODE_OVER;
              end
            end else if (tok_data_i == c_OP_RESULT) begin
              if (count_q >= c_ONE) begin
                state_d = POP_R;
              end else begin
                w_err      = 1'b1;
                w_err_code = c_CODE_UNDER;
              end
            end else if (w_op_legal) begin
              op_d = tok_data_i;
              if (count_q >= c_TWO) begin
                state_d = POP_B;
              end else begin
                w_err      = 1'b1;
                w_err_code = c_CODE_UNDER;
              end
            end else begin
              w_err      = 1'b1;
              w_err_code = c_CODE_FAULT;
            end
          end
        end
      end
      PUSH: begin
        stk_push_o    = 1'b1;
        stk_data_in_o = opnd_q;
        count_d       = count_q + c_ONE;
        post_push_d   = 1'b1;
        state_d       = IDLE;
      end
      POP_B: begin
        stk_pop_o = 1'b1;
        count_d   = count_q - c_ONE;
        state_d   = WAIT_B;
      end
      WAIT_B: begin
        if (stk_error_i) begin
          w_fault = 1'b1;
        end else begin
          b_d     = stk_data_out_i;
          state_d = POP_A;
        end
      end
      POP_A: begin
        stk_pop_o = 1'b1;
        count_d   = count_q - c_ONE;
        state_d   = WAIT_A;
      end
      WAIT_A: begin
        if (stk_error_i) begin
          w_fault = 1'b1;
        end else begin
          a_d     = stk_data_out_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        stk_push_o    = 1'b1;
        stk_data_in_o = w_alu;
        count_d       = count_q + c_ONE;
        post_push_d   = 1'b1;
        state_d       = IDLE;
      end
      POP_R: begin
        stk_pop_o = 1'b1;
        count_d   = count_q - c_ONE;
        state_d   = WAIT_R;
      end
      WAIT_R: begin
        if (stk_error_i) begin
          w_fault = 1'b1;
        end else begin
          res_data_d = stk_data_out_i;
          res_err_d  = 1'b0;
          res_code_d = 2'd0;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_err || w_fault) begin
      state_d    = OUT;
      res_data_d = '0;
      res_err_d  = 1'b1;
      res_code_d = w_fault ? c_CODE_FAULT : w_err_code;
    end
    // stack contents are unknown after a fault; software must reset it
    if (w_fault) begin
      count_d = '0;
    end

    if (reset) begin
      tok_ready_o   = 1'b0;
      stk_push_o    = 1'b0;
      stk_pop_o     = 1'b0;
      stk_data_in_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_code_q  <= 2'd0;
      post_push_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      opnd_q      <= opnd_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_code_q  <= res_code_d;
      post_push_q <= post_push_d;
    end
  end

  assign res_valid_o = (state_q == OUT);
  assign res_data_o  = res_data_q;
  assign res_err_o   = res_err_q;
  assign res_code_o  = res_code_q;

endmodule

`default_nettype wire
